dmem_mmio_bridge: RTL and testbench

- Sits directly downstream of the processor's data-memory port.
- Decodes the 12-bit dmem address. Ordinary addresses pass through to dmem; the top MMIO window maps to game peripherals: keyboard scancode FIFO, gravity tick timer, score register.
- Reads return data in the same cycle, as the single-cycle datapath requires. Read side effects (pop, clear) commit on the next rising clock edge.

---
 rtl/dmem_mmio_bridge.sv | 188 ++++++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_bridge
// Purpose  : Sits on the processor data-memory port. Addresses below
//            MMIO_BASE pass straight through to dmem; the top window maps a
//            keyboard scancode FIFO, a gravity tick timer and a score
//            register. Reads are combinational; read side effects (pop,
//            clear) commit on the next rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_mmio_bridge #(
  parameter int          DEPTH         = 8,
  parameter logic [11:0] MMIO_BASE     = 12'hFF8,
  parameter logic [11:0] KBD_DATA_ADDR = 12'hFFF,
  parameter logic [11:0] KBD_STAT_ADDR = 12'hFFE,
  parameter logic [11:0] TICK_ADDR     = 12'hFFD,
  parameter logic [11:0] PERIOD_ADDR   = 12'hFFC,
  parameter logic [11:0] SCORE_ADDR    = 12'hFFB
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] cpu_address,
  input  logic [31:0] cpu_data,
  input  logic        cpu_wren,
  input  logic        cpu_rden,
  output logic [31:0] cpu_q,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  input  logic [7:0]  kbd_code,
  input  logic        kbd_valid,
  output logic [31:0] score_out,
  output logic        tick_irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);

  // State flops
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      period_q, period_d;
  logic [31:0]      counter_q, counter_d;
  logic             tick_pending_q, tick_pending_d;
  logic [31:0]      score_q, score_d;

  // FIFO storage has no reset: validity is tracked purely by count_q
  logic [7:0]       fifo_q [DEPTH];

  // Decode and control strobes
  logic        is_mmio;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        wr_period;
  logic        wr_score;
  logic        rd_stat;
  logic        rd_tick;
  logic        tick_set;
  logic        ovf_set;
  logic [31:0] mmio_rdata;
  logic [31:0] stat_word;
  logic [7:0]  head;

  assign is_mmio   = (cpu_address >= MMIO_BASE);
  assign empty     = (count_q == '0);
  assign full      = (count_q == C_FULL_COUNT);
  assign head      = fifo_q[rd_ptr_q];

  assign pop       = cpu_rden & (cpu_address == KBD_DATA_ADDR) & ~empty;
  assign push      = kbd_valid & (~full | pop);
  assign ovf_set   = kbd_valid & full & ~pop;

  assign wr_period = cpu_wren & (cpu_address == PERIOD_ADDR);
  assign wr_score  = cpu_wren & (cpu_address == SCORE_ADDR);
  assign rd_stat   = cpu_rden & (cpu_address == KBD_STAT_ADDR);
  assign rd_tick   = cpu_rden & (cpu_address == TICK_ADDR);

  // Pass-through to dmem; stores into the MMIO window never reach memory
  assign mem_address = cpu_address;
  assign mem_data    = cpu_data;
  assign mem_wren    = cpu_wren & ~is_mmio & reset;

  assign score_out   = score_q;
  assign tick_irq    = tick_pending_q;

  // Status word: overflow, full, empty, count in the low byte
  always_comb begin
    stat_word        = 32'h0;
    stat_word[7:0]   = 8'(count_q);
    stat_word[8]     = empty;
    stat_word[9]     = full;
    stat_word[16]    = overflow_q;
  end

  // Zero-latency MMIO read mux and final load-data select
  always_comb begin
    mmio_rdata = 32'h0;
    case (cpu_address)
      KBD_DATA_ADDR: mmio_rdata = empty ? 32'h0 : {24'h0, head};
      KBD_STAT_ADDR: mmio_rdata = stat_word;
      TICK_ADDR:     mmio_rdata = {31'h0, tick_pending_q};
      PERIOD_ADDR:   mmio_rdata = period_q;
      SCORE_ADDR:    mmio_rdata = score_q;
      default:       mmio_rdata = 32'h0;
    endcase
    cpu_q = is_mmio ? mmio_rdata : mem_q;
  end

  // FIFO pointer/count and sticky overflow next-state
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A new drop in the same cycle as a status read keeps the flag set
    if (ovf_set)      overflow_d = 1'b1;
    else if (rd_stat) overflow_d = 1'b0;
  end

  // Timer, tick flag and score next-state
  always_comb begin
    period_d       = period_q;
    counter_d      = counter_q;
    score_d        = score_q;
    tick_set       = 1'b0;
    tick_pending_d = tick_pending_q;
    if (wr_period) begin
      period_d  = cpu_data;
      counter_d = 32'h0;
    end else if (period_q == 32'h0) begin
      counter_d = 32'h0;
    end else if (counter_q == period_q - 32'h1) begin
      counter_d = 32'h0;
      tick_set  = 1'b1;
    end else begin
      counter_d = counter_q + 32'h1;
    end
    if (wr_score) score_d = cpu_data;
    // A tick landing on the same edge as the acknowledging read wins
    if (tick_set)     tick_pending_d = 1'b1;
    else if (rd_tick) tick_pending_d = 1'b0;
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      period_q       <= 32'h0;
      counter_q      <= 32'h0;
      tick_pending_q <= 1'b0;
      score_q        <= 32'h0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      period_q       <= period_d;
      counter_q      <= counter_d;
      tick_pending_q <= tick_pending_d;
      score_q        <= score_d;
    end
  end

  // Scancode storage write; suppressed while reset is held
  always_ff @(posedge clock) begin
    if (reset && push) begin
      fifo_q[wr_ptr_q] <= kbd_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_bridge
// Purpose  : Directed self-checking bench for dmem_mmio_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_mmio_bridge;

  localparam logic [11:0] A_DATA   = 12'hFFF;
  localparam logic [11:0] A_STAT   = 12'hFFE;
  localparam logic [11:0] A_TICK   = 12'hFFD;
  localparam logic [11:0] A_PERIOD = 12'hFFC;
  localparam logic [11:0] A_SCORE  = 12'hFFB;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] cpu_address;
  logic [31:0] cpu_data;
  logic        cpu_wren;
  logic        cpu_rden;
  logic [31:0] cpu_q;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [7:0]  kbd_code;
  logic        kbd_valid;
  logic [31:0] score_out;
  logic        tick_irq;

  int checks = 0;
  int errors = 0;

  dmem_mmio_bridge #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_data(cpu_data),
    .cpu_wren(cpu_wren), .cpu_rden(cpu_rden), .cpu_q(cpu_q),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q),
    .kbd_code(kbd_code), .kbd_valid(kbd_valid),
    .score_out(score_out), .tick_irq(tick_irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] code);
    kbd_code  = code;
    kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    cpu_address = addr;
    cpu_rden    = 1'b1;
    #1 data = cpu_q;
    step();
    cpu_rden    = 1'b0;
    cpu_address = 12'h000;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    cpu_address = addr;
    cpu_data    = data;
    cpu_wren    = 1'b1;
    step();
    cpu_wren    = 1'b0;
    cpu_address = 12'h000;
  endtask

  logic [31:0] d;

  initial begin
    reset = 1'b0; cpu_address = 12'h010; cpu_data = 32'h0; cpu_wren = 1'b1;
    cpu_rden = 1'b0; mem_q = 32'h1234_5678; kbd_code = 8'h0; kbd_valid = 1'b0;
    #12;
    check("rst_score", score_out, 32'h0);
    check("rst_tick", {31'h0, tick_irq}, 32'h0);
    check("rst_wren", {31'h0, mem_wren}, 32'h0);
    cpu_wren = 1'b0; cpu_address = 12'h000;
    @(negedge clock); reset = 1'b1;
    step();

    // Pass-through
    cpu_address = 12'h010; cpu_data = 32'hDEAD_BEEF; cpu_wren = 1'b1;
    #1;
    check("pt_wren", {31'h0, mem_wren}, 32'h1);
    check("pt_addr", {20'h0, mem_address}, 32'h010);
    check("pt_data", mem_data, 32'hDEAD_BEEF);
    cpu_address = 12'hFFB;
    #1;
    check("mmio_wren", {31'h0, mem_wren}, 32'h0);
    step();
    cpu_wren = 1'b0; cpu_address = 12'h000;
    check("score_out", score_out, 32'hDEAD_BEEF);
    rd(12'h020, d);
    check("pt_load", d, 32'h1234_5678);
    rd(A_SCORE, d);
    check("score_rd", d, 32'hDEAD_BEEF);
    rd(12'hFF9, d);
    check("unmapped", d, 32'h0);

    // FIFO order
    push(8'h1C); push(8'h1D); push(8'h23);
    rd(A_STAT, d);  check("stat3", d, 32'h0000_0003);
    rd(A_DATA, d);  check("pop1", d, 32'h1C);
    rd(A_DATA, d);  check("pop2", d, 32'h1D);
    rd(A_DATA, d);  check("pop3", d, 32'h23);
    rd(A_DATA, d);  check("pop_empty", d, 32'h0);
    rd(A_STAT, d);  check("stat_empty", d, 32'h0000_0100);
    wr(A_DATA, 32'h77);
    rd(A_STAT, d);  check("wr_ignored", d, 32'h0000_0100);

    // Overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) push(8'h40 + 8'(i));
    rd(A_STAT, d);  check("stat_ovf", d, 32'h0001_0208);
    rd(A_STAT, d);  check("stat_ovf_clr", d, 32'h0000_0208);

    // Full with simultaneous push and pop
    kbd_code = 8'h99; kbd_valid = 1'b1;
    rd(A_DATA, d);  check("full_pushpop", d, 32'h40);
    kbd_valid = 1'b0;
    rd(A_STAT, d);  check("stat_full_pp", d, 32'h0000_0208);
    for (int i = 1; i < 8; i++) begin
      rd(A_DATA, d);
      check("drain", d, 32'h40 + 32'(i));
    end
    rd(A_DATA, d);  check("drain_new", d, 32'h99);
    rd(A_STAT, d);  check("stat_drained", d, 32'h0000_0100);

    // Push while empty is invisible to a same-cycle read
    kbd_code = 8'h55; kbd_valid = 1'b1;
    rd(A_DATA, d);  check("empty_push_rd", d, 32'h0);
    kbd_valid = 1'b0;
    rd(A_STAT, d);  check("stat_after_ep", d, 32'h0000_0001);
    rd(A_DATA, d);  check("pop_55", d, 32'h55);

    // Timer period 4
    wr(A_PERIOD, 32'd4);
    for (int i = 1; i < 4; i++) begin
      step();
      check("tick_wait", {31'h0, tick_irq}, 32'h0);
    end
    step();
    check("tick_rise", {31'h0, tick_irq}, 32'h1);
    rd(A_TICK, d);  check("tick_rd", d, 32'h1);
    check("tick_fall", {31'h0, tick_irq}, 32'h0);
    step(); step();
    check("tick_low", {31'h0, tick_irq}, 32'h0);
    rd(A_TICK, d);  check("tick_rd_coinc", d, 32'h0);
    check("tick_set_wins", {31'h0, tick_irq}, 32'h1);
    rd(A_PERIOD, d); check("period_rd", d, 32'd4);
    wr(A_PERIOD, 32'd0);
    rd(A_TICK, d);  check("tick_rd2", d, 32'h1);
    for (int i = 0; i < 10; i++) step();
    check("no_tick_p0", {31'h0, tick_irq}, 32'h0);

    // Period 1 ticks every cycle
    wr(A_PERIOD, 32'd1);
    step();
    check("p1_tick", {31'h0, tick_irq}, 32'h1);
    rd(A_TICK, d);  check("p1_rd", d, 32'h1);
    check("p1_stays", {31'h0, tick_irq}, 32'h1);

    // Async reset mid-operation
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
    wr(A_SCORE, 32'h0000_1234);
    check("pre_score", score_out, 32'h0000_1234);
    check("pre_tick", {31'h0, tick_irq}, 32'h1);
    rd(A_STAT, d);  check("pre_count", d, 32'h0000_0005);
    #2 reset = 1'b0;
    #1;
    check("ar_score", score_out, 32'h0);
    check("ar_tick", {31'h0, tick_irq}, 32'h0);
    cpu_address = A_STAT;
    #1;
    check("ar_stat", cpu_q, 32'h0000_0100);
    cpu_address = 12'h000;
    @(negedge clock); reset = 1'b1;
    step(); step();
    check("post_tick", {31'h0, tick_irq}, 32'h0);
    rd(A_PERIOD, d); check("post_period", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
